uart_key_decoder: RTL

Byte-stream decoder between the UART receiver and the game `control` block. It turns received terminal bytes into single-cycle `state_type` command pulses. It handles plain letter keys, ANSI CSI arrow sequences (ESC `[` A..D) and SS3 arrow sequences (ESC `O` A..D). A timeout discards incomplete escape sequences. `control` consumes `cmd`/`cmd_valid` in place of raw `received`/`rx_byte`.

---
 rtl/enum_type_pkg.sv | 43 ++++
 rtl/uart_key_decoder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/enum_type_pkg.sv
// rtl/enum_type_pkg.sv - shared game command enum plus key decoder types and helpers
package enum_type;

    typedef enum logic [3:0] {
        NONE,
        LEFT,
        RIGHT,
        DOWN,
        DROP,
        HOLD,
        ROTATE,
        ROTATE_REV,
        BAR
    } state_type;

    typedef enum logic [1:0] {
        IDLE,
        ESC,
        CSI,
        SS3
    } key_fsm_type;

    localparam logic [7:0] ESC_BYTE = 8'h1B;
    localparam logic [7:0] CSI_BYTE = 8'h5B;
    localparam logic [7:0] SS3_BYTE = 8'h4F;

    function automatic state_type map_plain(input logic [7:0] b);
        state_type r;
        case (b)
            8'h61, 8'h41:        r = LEFT;
            8'h64, 8'h44:        r = RIGHT;
            8'h73, 8'h53:        r = DOWN;
            8'h77, 8'h57, 8'h20: r = DROP;
            8'h63, 8'h43:        r = HOLD;
            8'h78, 8'h58:        r = ROTATE;
            8'h7A, 8'h5A:        r = ROTATE_REV;
            8'h62, 8'h42:        r = BAR;
            default:             r = NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_key_decoder.sv
// rtl/uart_key_decoder.sv - turns UART terminal bytes (plain keys, CSI/SS3 arrows) into command pulses
module uart_key_decoder
    import enum_type::*;
#(
    parameter int ESC_TIMEOUT = 2_000_000,
    parameter int MAX_PARAM   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       recv_error,
    output state_type  cmd,
    output logic       cmd_valid,
    output logic       any_key,
    output logic       esc_pending
);

    localparam int TW = $clog2(ESC_TIMEOUT);
    localparam int PW = $clog2(MAX_PARAM + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ESC_TIMEOUT - 1);
    localparam logic [PW-1:0] PARAM_MAX  = PW'(MAX_PARAM);

    key_fsm_type   r_state;
    logic [TW-1:0] r_timer;
    logic [PW-1:0] r_param_cnt;
    state_type     r_cmd;
    logic          r_cmd_valid;
    logic          r_any_key;
    logic          r_esc_pending;

    state_type w_plain;
    state_type w_arrow;
    logic      w_is_param;
    logic      w_is_final;
    logic      w_timeout;

    assign w_plain    = map_plain(rx_byte);
    assign w_is_param = (rx_byte[7:4] == 4'h3);
    assign w_is_final = (rx_byte >= 8'h40) && (rx_byte <= 8'h7E);
    assign w_timeout  = (r_timer == TIMER_LAST);

    always_comb begin
        w_arrow = NONE;
        case (rx_byte)
            8'h41:   w_arrow = ROTATE;
            8'h42:   w_arrow = DOWN;
            8'h43:   w_arrow = RIGHT;
            8'h44:   w_arrow = LEFT;
            default: w_arrow = NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_param_cnt   <= '0;
            r_cmd         <= NONE;
            r_cmd_valid   <= 1'b0;
            r_any_key     <= 1'b0;
            r_esc_pending <= 1'b0;
        end else begin
            r_cmd       <= NONE;
            r_cmd_valid <= 1'b0;
            r_any_key   <= 1'b0;
            // A framing error poisons the byte and any sequence in flight.
            if (recv_error) begin
                r_state       <= IDLE;
                r_timer       <= '0;
                r_param_cnt   <= '0;
                r_esc_pending <= 1'b0;
            end else if (received) begin
                r_timer <= '0;
                case (r_state)
                    IDLE: begin
                        if (rx_byte == ESC_BYTE) begin
                            r_state       <= ESC;
                            r_esc_pending <= 1'b1;
                        end else begin
                            r_cmd       <= w_plain;
                            r_cmd_valid <= (w_plain != NONE);
                            r_any_key   <= 1'b1;
                        end
                    end
                    ESC: begin
                        if (rx_byte == CSI_BYTE) begin
                            r_state     <= CSI;
                            r_param_cnt <= '0;
                        end else if (rx_byte == SS3_BYTE) begin
                            r_state <= SS3;
                        end else if (rx_byte != ESC_BYTE) begin
                            r_state       <= IDLE;
                            r_esc_pending <= 1'b0;
                            r_cmd         <= w_plain;
                            r_cmd_valid   <= (w_plain != NONE);
                            r_any_key     <= 1'b1;
                        end
                    end
                    CSI: begin
                        if (w_is_param) begin
                            if (r_param_cnt == PARAM_MAX) begin
                                r_state       <= IDLE;
                                r_esc_pending <= 1'b0;
                            end else begin
                                r_param_cnt <= r_param_cnt + PW'(1);
                            end
                        end else begin
                            r_state       <= IDLE;
                            r_esc_pending <= 1'b0;
                            if (w_is_final) begin
                                r_cmd       <= w_arrow;
                                r_cmd_valid <= (w_arrow != NONE);
                                r_any_key   <= 1'b1;
                            end
                        end
                    end
                    SS3: begin
                        r_state       <= IDLE;
                        r_esc_pending <= 1'b0;
                        r_cmd         <= w_arrow;
                        r_cmd_valid   <= (w_arrow != NONE);
                        r_any_key     <= 1'b1;
                    end
                    default: begin
                        r_state       <= IDLE;
                        r_esc_pending <= 1'b0;
                    end
                endcase
            end else if (r_state != IDLE) begin
                if (w_timeout) begin
                    r_state       <= IDLE;
                    r_timer       <= '0;
                    r_esc_pending <= 1'b0;
                end else begin
                    r_timer <= r_timer + TW'(1);
                end
            end else begin
                r_timer <= '0;
            end
        end
    end

    assign cmd         = r_cmd;
    assign cmd_valid   = r_cmd_valid;
    assign any_key     = r_any_key;
    assign esc_pending = r_esc_pending;

endmodule
